axis_reg_writer: RTL

AXIS slave that consumes byte frames and turns each into a burst of register writes. First beat of a frame carries the start register address; every following beat writes one data byte to consecutive, auto-incremented addresses until `tlast`. It sits downstream of the SPI byte path, at the consumer end of the `AXIS` interface, and feeds the chip register file through a valid/ready write port. Frames whose `tdest` does not match are discarded and counted.

---
 rtl/axis_reg_writer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/axis_reg_writer.sv
// axis_reg_writer: turns AXI-Stream byte frames into bursts of register writes.
// The first beat of a matching frame sets the start address, and every later beat
// writes one byte to the next auto-incremented address. Frames addressed to
// another destination are discarded and counted.
module axis_reg_writer #(
    parameter int          ADDR_W  = 8,
    parameter logic [3:0]  DEST_ID = 4'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_axis_tdata,
    input  logic [3:0]        s_axis_tdest,
    input  logic [1:0]        s_axis_tid,
    input  logic [3:0]        s_axis_tuser,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              reg_wr_valid,
    input  logic              reg_wr_ready,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic [1:0]        reg_wr_id,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_DROP
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addrPtr;
    logic [1:0]         r_idQ;
    logic               r_wrValid;
    logic [ADDR_W-1:0]  r_regAddr;
    logic [7:0]         r_regWdata;
    logic [1:0]         r_regWrId;
    logic [15:0]        r_frameCnt;
    logic [7:0]         r_dropCnt;

    logic               w_tready;
    logic               w_accept;
    logic               w_unused;

    // tuser carries nothing for us, and the high address-byte bits are unused for narrow ADDR_W
    assign w_unused = ^{s_axis_tuser, s_axis_tdata};

    // Only DATA can stall, and only when the output register is full and not being drained
    always_comb begin
        w_tready = 1'b1;
        if (r_state == S_DATA) begin
            w_tready = !r_wrValid || reg_wr_ready;
        end
    end

    assign w_accept = s_axis_tvalid && w_tready;

    // Frame parser, address pointer, write output register and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addrPtr  <= '0;
            r_idQ      <= '0;
            r_wrValid  <= 1'b0;
            r_regAddr  <= '0;
            r_regWdata <= '0;
            r_regWrId  <= '0;
            r_frameCnt <= '0;
            r_dropCnt  <= '0;
        end else begin
            if (reg_wr_ready) begin
                r_wrValid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (s_axis_tdest != DEST_ID) begin
                            if (r_dropCnt != 8'hFF) begin
                                r_dropCnt <= r_dropCnt + 8'd1;
                            end
                            if (!s_axis_tlast) begin
                                r_state <= S_DROP;
                            end
                        end else begin
                            r_addrPtr <= s_axis_tdata[ADDR_W-1:0];
                            r_idQ     <= s_axis_tid;
                            if (s_axis_tlast) begin
                                if (r_frameCnt != 16'hFFFF) begin
                                    r_frameCnt <= r_frameCnt + 16'd1;
                                end
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_wrValid  <= 1'b1;
                        r_regAddr  <= r_addrPtr;
                        r_regWdata <= s_axis_tdata;
                        r_regWrId  <= r_idQ;
                        r_addrPtr  <= r_addrPtr + ADDR_W'(1);
                        if (s_axis_tlast) begin
                            if (r_frameCnt != 16'hFFFF) begin
                                r_frameCnt <= r_frameCnt + 16'd1;
                            end
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (w_accept && s_axis_tlast) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = w_tready;
    assign reg_wr_valid  = r_wrValid;
    assign reg_addr      = r_regAddr;
    assign reg_wdata     = r_regWdata;
    assign reg_wr_id     = r_regWrId;
    assign busy          = (r_state != S_IDLE) || r_wrValid;
    assign frame_cnt     = r_frameCnt;
    assign drop_cnt      = r_dropCnt;

endmodule
